relu_maxpool: RTL and testbench

Streaming ReLU plus 2×2/stride-2 max-pool stage that sits directly downstream of the convolution layer. It consumes one feature map's convolution results in raster order, one value per cycle, over a valid/ready handshake. It emits the pooled map, 12×12 for the default 24×24 input, in raster order over a second valid/ready handshake. One instance serves one feature channel; the design replicates it once per convolution filter.

---
 rtl/relu_maxpool_if.sv | 33 +++
 rtl/relu_maxpool.sv | 114 +++++++++++
 tb/tb_relu_maxpool.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/relu_maxpool_if.sv
// relu_maxpool_if
//   Groups the input and output valid/ready streams of one ReLU + 2x2 max-pool
//   channel.
//   Input stream (into the block):
//     in_valid, in_data[DATA_W] (signed conv value) and in_ready (back to the producer).
//   Output stream (out of the block):
//     out_valid, out_data[DATA_W] (pooled, >= 0), out_last (final beat of a frame)
//     and out_ready (back from the consumer).
//   frame_done is a one-cycle pulse after the out_last beat is accepted.
//   modport slave  : the pooling block.
//   modport master : the environment that drives the stream and consumes it.
interface relu_maxpool_if #(
  parameter int DATA_W = 45
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              frame_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done
  );
endinterface

// File: rtl/relu_maxpool.sv
// relu_maxpool
//   Streaming ReLU followed by 2x2/stride-2 max-pool for one feature channel.
//   Conv results arrive in row-major order, one per accepted beat. The pooled
//   map leaves in row-major order through a single-entry output register.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-low reset
//     bus : relu_maxpool_if.slave (in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data/out_last, frame_done)
//   Parameters:
//     DATA_W : signed conv value width
//     IN_X   : input rows; must be even
//     IN_Y   : input columns; must be even
module relu_maxpool #(
  parameter int DATA_W = 45,
  parameter int IN_X   = 24,
  parameter int IN_Y   = 24
) (
  input logic          clk,
  input logic          rst,
  relu_maxpool_if.slave bus
);
  localparam int RW   = (IN_X > 1) ? $clog2(IN_X) : 1;
  localparam int CW   = (IN_Y > 1) ? $clog2(IN_Y) : 1;
  localparam int LB_N = IN_Y / 2;
  localparam int LW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  if ((IN_X % 2) != 0 || (IN_Y % 2) != 0 || IN_X < 2 || IN_Y < 2) begin : g_bad_dims
    $error("relu_maxpool: IN_X and IN_Y must be even and at least 2");
  end

  logic [RW-1:0]            r;
  logic [CW-1:0]            c;
  logic signed [DATA_W-1:0] h;
  logic signed [DATA_W-1:0] lb [LB_N];

  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] pair;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] pooled;
  logic [DATA_W-1:0]        relu_val;
  logic [LW-1:0]            lb_idx;
  logic                     accept;
  logic                     load;
  logic                     last_c;
  logic                     last_r;

  logic              out_valid_q;
  logic              out_last_q;
  logic              frame_done_q;
  logic [DATA_W-1:0] out_data_q;

  // Every beat, emitting or not, waits for room in the output register.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign din    = $signed(bus.in_data);
  assign last_c = (c == CW'(IN_Y - 1));
  assign last_r = (r == RW'(IN_X - 1));
  assign lb_idx = LW'(c >> 1);
  assign lb_rd  = lb[lb_idx];

  assign pair   = (h > din) ? h : din;
  assign pooled = (lb_rd > pair) ? lb_rd : pair;
  // ReLU after the max: max(relu(x)) == relu(max(x)), so one clamp suffices.
  assign relu_val = pooled[DATA_W-1] ? '0 : pooled;

  assign load = accept && r[0] && c[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r            <= '0;
      c            <= '0;
      h            <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_valid_q && bus.out_ready && out_last_q;

      if (accept) begin
        if (last_c) begin
          c <= '0;
          r <= last_r ? '0 : r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
        if (!c[0]) h <= din;
      end

      // A load can only happen when the register is empty or draining this
      // cycle, so replacing the contents never drops an undelivered value.
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= relu_val;
        out_last_q  <= last_r && last_c;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  // Line buffer is never read before an even row has written it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && !r[0] && c[0]) lb[lb_idx] <= pair;
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool
//   Drives whole frames through relu_maxpool and checks every pooled beat
//   against a window-max reference computed from the frame image.
module tb_relu_maxpool;
  localparam int DW = 45;
  localparam int NX = 24;
  localparam int NY = 24;
  localparam int NO = (NX / 2) * (NY / 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu_maxpool_if #(.DATA_W(DW)) bus ();

  relu_maxpool #(.DATA_W(DW), .IN_X(NX), .IN_Y(NY)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  typedef struct {
    longint a;
    longint b;
    longint c;
    longint d;
    longint expv;
  } vec_t;

  longint img [NX][NY];
  exp_t   exp_q [$];
  exp_t   e_mon;
  longint got [$];
  longint ramp_ref [$];
  int     checks = 0;
  int     passes = 0;
  int     ready_pct = 100;
  int     fd_cnt = 0;
  bit     fd_pend = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Reference: each pooled output is the largest of its four window cells,
  // clamped at zero; the final window of the frame carries last.
  task automatic build_expected();
    for (int i = 0; i < NX / 2; i++) begin
      for (int j = 0; j < NY / 2; j++) begin
        longint m;
        exp_t e;
        m = img[2*i][2*j];
        if (img[2*i][2*j+1]   > m) m = img[2*i][2*j+1];
        if (img[2*i+1][2*j]   > m) m = img[2*i+1][2*j];
        if (img[2*i+1][2*j+1] > m) m = img[2*i+1][2*j+1];
        e.data = (m < 0) ? 0 : m;
        e.last = (i == NX / 2 - 1) && (j == NY / 2 - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_ramp(input longint offset);
    for (int r = 0; r < NX; r++)
      for (int c = 0; c < NY; c++)
        img[r][c] = longint'(r * NY + c) + offset;
  endtask

  function automatic longint rand_val();
    longint v;
    v = {$urandom, $urandom};
    v = (v <<< 19) >>> 19;  // sign-extend a 45-bit value
    if ($urandom_range(3) == 0) v = v % 1000;
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < NX; r++)
      for (int c = 0; c < NY; c++)
        img[r][c] = rand_val();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.out_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic send_img(input int nbeats, input int pv);
    for (int k = 0; k < nbeats; k++) begin
      int guard;
      bit sent;
      guard = 0;
      sent  = 1'b0;
      bus.in_data = DW'(img[k / NY][k % NY]);
      while (!sent && guard < 200) begin
        bus.in_valid = ($urandom_range(99) < pv);
        #1;
        sent = bus.in_valid && bus.in_ready;
        step();
        guard++;
      end
      if (!sent) begin
        chk("in_accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 5000) begin
      step();
      g++;
    end
    chk("drain_complete", exp_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic start_test(input int rp);
    ready_pct = rp;
    got.delete();
    fd_cnt = 0;
  endtask

  // Output monitor: sampled on the falling edge, when inputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      fd_pend = 1'b0;
    end else begin
      chk("frame_done", bus.frame_done, fd_pend);
      if (bus.frame_done) fd_cnt++;
      fd_pend = bus.out_valid && bus.out_ready && bus.out_last;
      chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", longint'(bus.out_data), -1);
        end else begin
          e_mon = exp_q.pop_front();
          chk("out_data", longint'(bus.out_data), e_mon.data);
          chk("out_last", bus.out_last, e_mon.last);
        end
        got.push_back(longint'(bus.out_data));
      end
    end
  end

  vec_t tv [6];

  initial begin
    tv[0] = '{a: -5, b: -3, c: -7, d: -1, expv: 0};
    tv[1] = '{a: -5, b: 3, c: -(longint'(1) <<< 44), d: 2, expv: 3};
    tv[2] = '{a: (longint'(1) <<< 44) - 1, b: 0, c: 0, d: 0, expv: (longint'(1) <<< 44) - 1};
    tv[3] = '{a: -(longint'(1) <<< 44), b: -(longint'(1) <<< 44), c: -(longint'(1) <<< 44),
              d: -(longint'(1) <<< 44), expv: 0};
    tv[4] = '{a: 0, b: -1, c: 1, d: -1, expv: 1};
    tv[5] = '{a: 7, b: 7, c: 7, d: 7, expv: 7};

    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values with random inputs toggling
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = $urandom_range(1);
      bus.in_data   = DW'({$urandom, $urandom});
      bus.out_ready = $urandom_range(1);
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_in_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    start_test(100);
    step();

    // Ramp frame, no stalls
    start_test(100);
    fill_ramp(0);
    build_expected();
    send_img(NX * NY, 100);
    drain();
    chk("ramp_count", got.size(), NO);
    chk("ramp_first", (got.size() > 0) ? got[0] : -1, 25);
    chk("ramp_i1j1", (got.size() > 13) ? got[13] : -1, 3 * 24 + 3);
    chk("ramp_last", (got.size() == NO) ? got[NO-1] : -1, 575);
    chk("ramp_frame_done", fd_cnt, 1);
    ramp_ref = got;

    // ReLU / sign vectors placed in windows (k, k+1) of a ramp frame
    start_test(100);
    fill_ramp(0);
    for (int k = 0; k < 6; k++) begin
      img[2*k][2*(k+1)]       = tv[k].a;
      img[2*k][2*(k+1)+1]     = tv[k].b;
      img[2*k+1][2*(k+1)]     = tv[k].c;
      img[2*k+1][2*(k+1)+1]   = tv[k].d;
    end
    build_expected();
    send_img(NX * NY, 100);
    drain();
    for (int k = 0; k < 6; k++) begin
      int w;
      w = k * (NY / 2) + k + 1;
      chk($sformatf("relu_vec_%0d", k), (got.size() > w) ? got[w] : -1, tv[k].expv);
    end

    // Backpressure on both sides, ramp frame
    start_test(70);
    fill_ramp(0);
    build_expected();
    send_img(NX * NY, 70);
    drain();
    begin
      int nmis;
      nmis = 0;
      if (got.size() != ramp_ref.size()) nmis = NO;
      else for (int k = 0; k < NO; k++) if (got[k] != ramp_ref[k]) nmis++;
      chk("bp_seq_mismatches", nmis, 0);
    end
    chk("bp_frame_done", fd_cnt, 1);

    // Random data with random stalls
    start_test(50);
    fill_random();
    build_expected();
    send_img(NX * NY, 60);
    drain();
    chk("rand_count", got.size(), NO);

    // Back-to-back frames, second offset by 1000
    start_test(100);
    fill_ramp(0);
    build_expected();
    send_img(NX * NY, 100);
    fill_ramp(1000);
    build_expected();
    send_img(NX * NY, 100);
    drain();
    chk("b2b_count", got.size(), 2 * NO);
    chk("b2b_second_first", (got.size() > NO) ? got[NO] : -1, 1025);
    chk("b2b_frame_done", fd_cnt, 2);

    // Reset in the middle of a frame, then a fresh frame
    start_test(70);
    fill_ramp(0);
    build_expected();
    send_img(300, 80);
    rst = 1'b0;
    exp_q.delete();
    step();
    step();
    rst = 1'b1;
    start_test(100);
    step();
    build_expected();
    send_img(NX * NY, 100);
    drain();
    chk("rst_mid_count", got.size(), NO);
    chk("rst_mid_first", (got.size() > 0) ? got[0] : -1, 25);
    chk("rst_mid_frame_done", fd_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
